// File: rtl/peripheral_uart_rx_if.sv
// -----------------------------------------------------------------------------
// peripheral_uart_rx_if
//
// Purpose : J1 I/O bus bundle between the CPU/address decoder and the UART
//           receive peripheral.
//
// Signals :
//   d_in      16  J1 write data                     (master -> slave)
//   cs         1  chip-select from the address decoder (master -> slave)
//   addr       4  register select, j1_io_addr[3:0]  (master -> slave)
//   rd         1  J1 read strobe                    (master -> slave)
//   wr         1  J1 write strobe                   (master -> slave)
//   d_out     16  registered read data              (slave -> master)
//   rx_avail   1  high while the receive FIFO holds data (slave -> master)
//
// Modports: master = CPU side, slave = peripheral side.
// -----------------------------------------------------------------------------
interface peripheral_uart_rx_if;
    logic [15:0] d_in;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;
    logic        rx_avail;

    modport master (
        output d_in,
        output cs,
        output addr,
        output rd,
        output wr,
        input  d_out,
        input  rx_avail
    );

    modport slave (
        input  d_in,
        input  cs,
        input  addr,
        input  rd,
        input  wr,
        output d_out,
        output rx_avail
    );
endinterface

// File: rtl/peripheral_uart_rx.sv
// -----------------------------------------------------------------------------
// peripheral_uart_rx
//
// Purpose : J1-bus UART receiver. Deserialises 8N1 frames (8E1 when the
//           UART_RX_PARITY_EN macro is defined) from an asynchronous serial
//           pin into a 2^FIFO_AW-entry byte FIFO that the CPU reads through a
//           small register map. Receive errors are kept in sticky status bits.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit (>= 8)
//   FIFO_AW       FIFO address width, depth = 2^FIFO_AW
//
// Ports :
//   clk   in   system clock, the only clock
//   rst   in   synchronous active-high reset
//   rx    in   asynchronous serial input, idle high
//   bus   slave modport of peripheral_uart_rx_if (d_in, cs, addr, rd, wr,
//         d_out, rx_avail)
//
// Register map (unlisted addresses read 0x0000):
//   0x0 DATA   R  {8'h00, byte}, pops one entry; 0x0000 when empty
//   0x2 STATUS R  [0] not empty [1] full [2] overrun [3] framing error
//                 [7:4] count [8] busy [9] parity error
//   0x4 CTRL   W  [0] clear sticky errors, [1] flush FIFO
//
// Build option: UART_RX_PARITY_EN adds an even-parity bit after the data bits.
// -----------------------------------------------------------------------------
module peripheral_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    peripheral_uart_rx_if.slave  bus
);

    localparam int SYNC_STAGES = 2;
    localparam int TW          = $clog2(CLKS_PER_BIT);
    localparam int DEPTH       = 1 << FIFO_AW;
    localparam int CW          = FIFO_AW + 1;

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchroniser. Each stage resets to the idle line level so that a
    // reset never looks like a start bit.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic stage_q;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) stage_q <= 1'b1;
                    else     stage_q <= rx;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) stage_q <= 1'b1;
                    else     stage_q <= g_sync[gi-1].stage_q;
                end
            end
        end
    endgenerate

    logic rx_s;
    assign rx_s = g_sync[SYNC_STAGES-1].stage_q;

    // -------------------------------------------------------------------------
    // Receive FSM
    // -------------------------------------------------------------------------
    state_t        state_q,   state_d;
    logic [TW-1:0] timer_q,   timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q,   shift_d;
`ifdef UART_RX_PARITY_EN
    logic          parity_ok_q, parity_ok_d;
`endif

    logic push_req;
    logic frame_set;
    logic parity_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
`ifdef UART_RX_PARITY_EN
            parity_ok_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
`ifdef UART_RX_PARITY_EN
            parity_ok_q <= parity_ok_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
`ifdef UART_RX_PARITY_EN
        parity_ok_d = parity_ok_q;
`endif
        push_req    = 1'b0;
        frame_set   = 1'b0;
        parity_set  = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d   = '0;
                bit_cnt_d = '0;
                if (!rx_s) state_d = S_START;
            end

            // Re-check the line half a bit later; a high line means the
            // falling edge was noise and no frame is started.
            S_START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            // LSB arrives first, so shift in from the top.
            S_DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d   = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            // Even parity: the parity bit equals the XOR of the data bits.
            S_PARITY: begin
                if (timer_q == BIT_LAST) begin
                    timer_d     = '0;
                    parity_ok_d = (rx_s == ^shift_q);
                    state_d     = S_STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`endif

            S_STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        if (parity_ok_q) push_req   = 1'b1;
                        else             parity_set = 1'b1;
`else
                        push_req = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_BREAK;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            // Line held low past the stop bit: wait for it to return to idle
            // so the remainder of the break is not taken as a new start bit.
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Bus access decode: one access per rising edge of the qualified strobe.
    // -------------------------------------------------------------------------
    logic rd_prev_q, wr_prev_q;
    logic rd_lvl, wr_lvl, rd_evt, wr_evt;
    logic data_rd, ctrl_wr, clr_err, flush;

    assign rd_lvl  = bus.cs & bus.rd;
    assign wr_lvl  = bus.cs & bus.wr;
    assign rd_evt  = rd_lvl & ~rd_prev_q;
    assign wr_evt  = wr_lvl & ~wr_prev_q;
    assign data_rd = rd_evt & (bus.addr == 4'h0);
    assign ctrl_wr = wr_evt & (bus.addr == 4'h4);
    assign clr_err = ctrl_wr & bus.d_in[0];
    assign flush   = ctrl_wr & bus.d_in[1];

    wire unused_ok = &{1'b0, bus.d_in[15:2]};

    // -------------------------------------------------------------------------
    // Byte FIFO
    // -------------------------------------------------------------------------
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic               empty, full, pop, do_push, ovr_set;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign pop   = data_rd & ~empty;

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still lands. Flush discards any push of the same cycle.
    assign do_push = push_req & ~flush & (~full | pop);
    assign ovr_set = push_req & ~flush & full & ~pop;

    assign count_d = count_q + {{FIFO_AW{1'b0}}, do_push} - {{FIFO_AW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end

    // -------------------------------------------------------------------------
    // Status word and read mux
    // -------------------------------------------------------------------------
    logic        overrun_q, frame_err_q, parity_err_q;
    logic [3:0]  cnt_field;
    logic        busy;
    logic [15:0] status;
    logic [15:0] rd_data;
    logic [15:0] d_out_q;

    assign cnt_field = 4'(count_q);
    assign busy      = (state_q != S_IDLE);
    assign status    = {6'b0, parity_err_q, busy, cnt_field,
                        frame_err_q, overrun_q, full, ~empty};

    always_comb begin
        rd_data = 16'h0000;
        case (bus.addr)
            4'h0:    rd_data = empty ? 16'h0000 : {8'h00, mem_q[rd_ptr_q]};
            4'h2:    rd_data = status;
            default: rd_data = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_prev_q    <= 1'b0;
            wr_prev_q    <= 1'b0;
            d_out_q      <= 16'h0000;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rd_prev_q <= rd_lvl;
            wr_prev_q <= wr_lvl;

            if (rd_evt) d_out_q <= rd_data;

            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_d;
            end

            // A new error in the clearing cycle is kept rather than lost.
            if (ovr_set)        overrun_q    <= 1'b1;
            else if (clr_err)   overrun_q    <= 1'b0;
            if (frame_set)      frame_err_q  <= 1'b1;
            else if (clr_err)   frame_err_q  <= 1'b0;
            if (parity_set)     parity_err_q <= 1'b1;
            else if (clr_err)   parity_err_q <= 1'b0;
        end
    end

    assign bus.d_out    = d_out_q;
    assign bus.rx_avail = ~empty;

endmodule

// File: doc/peripheral_uart_rx.md
# peripheral_uart_rx

J1-bus UART receiver peripheral: deserialises 8N1 frames from an asynchronous serial input (e.g. `bt_rx`) into an 8-entry byte FIFO readable by the J1 CPU. Complements the transmit-only UART peripheral. Sits beside the other `peripheral_*` blocks on the J1 I/O bus behind its own address-decoder chip-select. Reports receive errors through sticky status bits.

## Interface
- `CLKS_PER_BIT`, 434, `clk` cycles per bit (50 MHz / 115200); minimum 8.
- `FIFO_AW`, 3, FIFO address width; depth = 2^FIFO_AW = 8.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `d_in`  in  16  J1 write data.
- `cs`  in  1  chip-select from the address decoder.
- `addr`  in  4  register select (`j1_io_addr[3:0]`).
- `rd`  in  1  J1 read strobe.
- `wr`  in  1  J1 write strobe.
- `d_out`  out  16  registered read data.
- `rx`  in  1  asynchronous serial input, idle high.
- `rx_avail`  out  1  high while the FIFO is non-empty.

## Operation
- `rx` passes through a 2-FF synchroniser (`rx_s`), which adds 2 cycles of latency.
- Register map (reads of unlisted addresses return 0x0000):
  - 0x0 DATA (R): `{8'h00, byte}` and pops one entry. If the FIFO is empty, returns 0x0000 with no pop.
  - 0x2 STATUS (R), no side effects:
    - bit0: not empty.
    - bit1: full.
    - bit2: overrun (sticky).
    - bit3: framing error (sticky).
    - bits[7:4]: entry count, 0..8.
    - bit8: busy (FSM not in IDLE).
    - bit9: parity error (sticky).
    - other bits 0.
  - 0x4 CTRL (W):
    - `d_in[0]=1` clears bits 2, 3 and 9.
    - `d_in[1]=1` flushes the FIFO.
    - other bits ignored.
- Bus access:
  - A read is the rising edge of `cs&rd`; a write is the rising edge of `cs&wr`.
  - One access per strobe, however long it is held.
  - `d_out` is registered on the access edge and holds until the next read access.
- Receive FSM:
  - IDLE: bit counter and timer cleared. `rx_s==0` → START.
  - START: wait CLKS_PER_BIT/2 cycles (integer division). If `rx_s==0` → DATA; otherwise it was a glitch → IDLE.
  - DATA: every CLKS_PER_BIT cycles, sample `rx_s` into a shift register, LSB first. After the 8th sample → STOP, or → PARITY when the parity option is compiled in.
  - PARITY (option only): after CLKS_PER_BIT cycles, sample and compare with even parity.
  - STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
    - 1 with parity OK: push the byte → IDLE.
    - 1 with a parity mismatch: set bit9, discard the byte → IDLE.
    - 0: set bit3, discard the byte → BREAK.
  - BREAK: wait for `rx_s==1` → IDLE.
- FIFO behaviour:
  - Push while full: byte dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle while full: both occur, no overrun.
  - Push and pop in the same cycle while empty: the pop returns 0x0000 and the push lands, so count becomes 1.
  - Flush and push in the same cycle: flush wins and the byte is discarded.
  - Read/write pointers wrap modulo 2^FIFO_AW. The count uses FIFO_AW+1 bits.

## Timing
- Reset values:
  - `d_out`=0x0000, `rx_avail`=0.
  - FIFO empty, all sticky bits 0.
  - FSM in IDLE, synchroniser flops = 1.
- Sampling instants:
  - Start bit is confirmed at CLKS_PER_BIT/2 after its falling edge is seen at `rx_s`.
  - Data bit k is sampled at (k+1)·CLKS_PER_BIT after confirmation.
- Latency:
  - The push occurs on the cycle the stop bit is sampled.
  - `rx_avail` and STATUS bit0 go high the following cycle.
  - End to end, 2 extra cycles of synchroniser delay apply relative to the pin.
- Read latency: `d_out` is valid 1 cycle after the read edge. The pop takes effect on that same edge.
- Reset asserted mid-frame aborts the frame: the partial byte is lost and the FSM returns to IDLE on the next edge.
- Flush mid-frame does not abort reception; the in-flight byte is pushed normally afterwards.

## Configuration
- `UART_RX_PARITY_EN` defined: frames are 8E1. The PARITY state is present, and a mismatch sets STATUS bit9 and discards the byte.
- `UART_RX_PARITY_EN` undefined: frames are 8N1. The PARITY state is omitted and bit9 always reads 0.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- Send 0xA5 8N1 → STATUS bit0=1, count=1. DATA read returns 0x00A5, then STATUS reads 0x0000.
- Send 9 bytes 0x01..0x09 without reading → count=8, full=1, overrun=1. Reads return 0x01..0x08, then a further read returns 0x0000.
- Drive `rx` low for 6 cycles, then high → no push, busy returns to 0, no error bits set.
- Send 0x3C with stop bit = 0 held low for 40 bit-times → bit3=1, FIFO empty, FSM in BREAK until `rx` rises. Write CTRL 0x0001 → bit3=0.
- With FIFO full, read DATA on the exact stop-sample cycle of the 9th byte → no overrun, count stays 8.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 → bit9=1, byte discarded. Send 0x07 with parity bit 1 → DATA read returns 0x0007.
